// File: rtl/chunked_adder_ctrl_if.sv
// Handshake and operand/result bundle for the chunked adder.
// The requester drives start/sub/a/b; the adder returns status and result.
interface chunked_adder_ctrl_if #(parameter int CHUNKS = 4);
    localparam int W = 3 * CHUNKS;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    modport master (output start, sub, a, b,
                    input  busy, done, result, c_out, overflow);
    modport slave  (input  start, sub, a, b,
                    output busy, done, result, c_out, overflow);
endinterface

// File: rtl/chunked_adder_ctrl.sv
// Wide add/subtract sequenced over one 3-bit ripple slice, LSB chunk first,
// with a carry register linking consecutive chunks.
module ripple_carry (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       cout
);
    logic [3:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 3; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[3];
endmodule

module chunked_adder_ctrl #(
    parameter int CHUNKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_adder_ctrl_if.slave  bus
);
    localparam int W  = 3 * CHUNKS;
    localparam int IW = $clog2(CHUNKS);
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg, b_reg, result;
    logic          carry_reg, c_out, overflow;
    logic [2:0]    a_chunk, b_chunk, sum;
    logic          cout;
    logic          accept, last;

    assign accept = (state != RUN) && bus.start;
    assign last   = (state == RUN) && (idx == LAST);

    // Chunk select keeps the slice inputs a plain mux, independent of W depth.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
                a_chunk = a_reg[3*i +: 3];
                b_chunk = b_reg[3*i +: 3];
            end
        end
    end

    ripple_carry u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_reg),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Subtract is a + ~b + 1: the operation kind lives entirely in the
    // inverted b_reg and the initial carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub;
            idx       <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < CHUNKS; i++) begin
                if (idx == IW'(i)) result[3*i +: 3] <= sum;
            end
            carry_reg <= cout;
            idx       <= idx + IW'(1);
            if (last) begin
                c_out    <= cout;
                overflow <= (a_reg[W-1] == b_reg[W-1]) && (sum[2] != a_reg[W-1]);
            end
        end
    end

    assign bus.result   = result;
    assign bus.c_out    = c_out;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_chunked_adder_ctrl.sv
// Bench for chunked_adder_ctrl: directed cases with literal expectations,
// then random traffic checked every cycle against an arithmetic model.
module tb_chunked_adder_ctrl;
    localparam int CHUNKS = 4;
    localparam int W      = 3 * CHUNKS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    chunked_adder_ctrl_if #(.CHUNKS(CHUNKS)) bus ();

    chunked_adder_ctrl #(.CHUNKS(CHUNKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one operation from plain integer arithmetic.
    task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] res, output logic c, output logic ov);
        longint ua, ub, r, sa, sb, sr;
        logic [63:0] rv;
        ua = longint'(a);
        ub = longint'(b);
        r  = sub ? ua - ub : ua + ub;
        rv = r;
        res = rv[W-1:0];
        c  = sub ? (ua >= ub) : (r >= (64'sd1 << W));
        sa = (ua >= (64'sd1 << (W-1))) ? ua - (64'sd1 << W) : ua;
        sb = (ub >= (64'sd1 << (W-1))) ? ub - (64'sd1 << W) : ub;
        sr = sub ? sa - sb : sa + sb;
        ov = (sr > (64'sd1 << (W-1)) - 1) || (sr < -(64'sd1 << (W-1)));
    endtask

    // Model: cnt = edges since the accepting edge (0 = idle).
    int           cnt = 0;
    logic [W-1:0] p_res, m_res = '0;
    logic         p_c, p_ov, m_c = 1'b0, m_ov = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt = 0; m_res = '0; m_c = 1'b0; m_ov = 1'b0;
        end else if ((cnt == 0 || cnt == CHUNKS + 1) && bus.start) begin
            calc(bus.a, bus.b, bus.sub, p_res, p_c, p_ov);
            cnt = 1; m_res = '0; m_c = 1'b0; m_ov = 1'b0;
        end else if (cnt == CHUNKS + 1) begin
            cnt = 0;
        end else if (cnt > 0) begin
            cnt++;
            if (cnt == CHUNKS + 1) begin
                m_res = p_res; m_c = p_c; m_ov = p_ov;
            end else begin
                m_res = p_res & W'((64'd1 << (3 * (cnt - 1))) - 1);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        chk("busy",     32'(bus.busy),     32'(cnt >= 1 && cnt <= CHUNKS));
        chk("done",     32'(bus.done),     32'(cnt == CHUNKS + 1));
        chk("result",   32'(bus.result),   32'(m_res));
        chk("c_out",    32'(bus.c_out),    32'(m_c));
        chk("overflow", 32'(bus.overflow), 32'(m_ov));
    end

    // Issue one op starting now (idle or DONE cycle), wait for done, pin literals.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] er, input logic ec,
                          input logic eov, input bit noise);
        int lat = 0, bc = 0;
        bit seen = 0;
        bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
        while (lat < 20 && !seen) begin
            @(negedge clk);
            lat++;
            bus.start = noise && (lat == 2);
            if (noise && lat == 2) begin
                bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
            end
            #2;
            if (bus.busy) bc++;
            if (bus.done) seen = 1;
        end
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"},   32'(lat),  32'(CHUNKS + 1));
        chk({nm, " busy_cyc"},  32'(bc),   32'(CHUNKS));
        chk({nm, " result"},    32'(bus.result),   32'(er));
        chk({nm, " c_out"},     32'(bus.c_out),    32'(ec));
        chk({nm, " overflow"},  32'(bus.overflow), 32'(eov));
    endtask

    initial begin
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst busy",   32'(bus.busy),   32'd0);
        chk("rst done",   32'(bus.done),   32'd0);
        chk("rst result", 32'(bus.result), 32'd0);
        chk("rst c_out",  32'(bus.c_out),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #2;

        run_op("add",     12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk); #2;
        run_op("carry",   12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 0);
        run_op("borrow",  12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0, 0);
        run_op("noborrow",12'h007, 12'h005, 1'b1, 12'h002, 1'b1, 1'b0, 0);
        run_op("ovf_add", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1, 0);
        run_op("ovf_sub", 12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b1, 0);
        run_op("ovf_neg", 12'h800, 12'hFFF, 1'b0, 12'h7FF, 1'b1, 1'b1, 0);
        @(negedge clk); #2;
        run_op("noise",   12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 1);
        run_op("b2b",     12'h001, 12'h001, 1'b0, 12'h002, 1'b0, 1'b0, 0);

        // Abort mid-operation at idx == 2.
        @(negedge clk); #2;
        bus.a = 12'h123; bus.b = 12'h456; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy",   32'(bus.busy),     32'd0);
        chk("abort result", 32'(bus.result),   32'd0);
        chk("abort c_out",  32'(bus.c_out),    32'd0);
        chk("abort ovf",    32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #2;
            chk("abort no_done", 32'(bus.done), 32'd0);
        end
        run_op("after_rst", 12'h0AA, 12'h055, 1'b0, 12'h0FF, 1'b0, 1'b0, 0);

        // Random traffic: start noise in every state, occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(3) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.sub   = 1'($urandom);
            rst       = ($urandom_range(399) == 0);
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
